armleocpu_jtag_dtm_ctrl: RTL and testbench

RISC-V debug transport controller that sits behind the JTAG TAP. It decodes the TAP instruction register and owns the IDCODE, BYPASS, DTMCS and DMI data registers. It turns TAP capture/shift/update events into DMI request/response handshakes toward the debug module. Everything runs on the system clock. TAP events are qualified by a one-cycle tck rising-edge strobe.

---
 rtl/armleocpu_jtag_dtm_ctrl.sv | 175 +++++++++++++++++
 tb/tb_armleocpu_jtag_dtm_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_jtag_dtm_ctrl.sv
// RISC-V debug transport module controller: decodes the TAP instruction, owns the
// IDCODE/BYPASS/DTMCS/DMI data registers and drives the DMI request/response handshake.
module armleocpu_jtag_dtm_ctrl #(
   parameter int          IR_LENGTH    = 5,
   parameter logic [31:0] IDCODE_VALUE = 32'h0000_0001,
   parameter int          ABITS        = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tck_rise_i,
   input  logic [IR_LENGTH-1:0] ir_i,
   input  logic                 capture_dr_i,
   input  logic                 shift_dr_i,
   input  logic                 update_dr_i,
   input  logic                 td_i,
   output logic                 tdo_o,
   output logic                 dmi_req_valid_o,
   input  logic                 dmi_req_ready_i,
   output logic [ABITS-1:0]     dmi_req_addr_o,
   output logic [31:0]          dmi_req_data_o,
   output logic [1:0]           dmi_req_op_o,
   input  logic                 dmi_resp_valid_i,
   output logic                 dmi_resp_ready_o,
   input  logic [31:0]          dmi_resp_data_i,
   input  logic                 dmi_resp_err_i
);

   localparam int DMI_W = ABITS + 34;
   localparam logic [IR_LENGTH-1:0] IR_IDCODE = IR_LENGTH'(5'h01);
   localparam logic [IR_LENGTH-1:0] IR_DTMCS  = IR_LENGTH'(5'h10);
   localparam logic [IR_LENGTH-1:0] IR_DMI    = IR_LENGTH'(5'h11);
   localparam logic [5:0] ABITS_FIELD = 6'(ABITS);
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;
   localparam logic [1:0] OP_BUSY  = 2'd3;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_RESP = 2'd2} state_t;
   typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_DTMCS, SEL_DMI} sel_t;

   // DMI handshake: a request is offered while dmi_req_valid_o=1 and transfers in the
   // cycle dmi_req_ready_i=1; a response transfers when dmi_resp_valid_i and
   // dmi_resp_ready_o are both 1. Valid is never withdrawn before the transfer.
   state_t             state_q;
   logic               req_valid_q;
   logic               resp_ready_q;
   logic [DMI_W-1:0]   sr_q;
   logic [DMI_W-1:0]   sr_d;
   logic [ABITS-1:0]   addr_q;
   logic [31:0]        data_q;
   logic [1:0]         op_q;
   logic [1:0]         sticky_q;
   logic               discard_q;

   sel_t               sel;
   logic               cap_ev;
   logic               shift_ev;
   logic               upd_ev;
   logic               busy;
   logic               resp_done;
   logic [31:0]        dtmcs_cap;
   logic [1:0]         dmi_cap_op;
   logic [1:0]         upd_op;
   logic [31:0]        upd_data;
   logic [ABITS-1:0]   upd_addr;

   always_comb begin
      sel = SEL_BYPASS;
      if (ir_i == IR_IDCODE)     sel = SEL_IDCODE;
      else if (ir_i == IR_DTMCS) sel = SEL_DTMCS;
      else if (ir_i == IR_DMI)   sel = SEL_DMI;
   end

   assign cap_ev     = tck_rise_i & capture_dr_i;
   assign shift_ev   = tck_rise_i & shift_dr_i;
   assign upd_ev     = tck_rise_i & update_dr_i;
   assign busy       = (state_q != ST_IDLE);
   assign resp_done  = (state_q == ST_RESP) & dmi_resp_valid_i;
   assign dtmcs_cap  = {14'd0, 2'b00, 1'b0, 3'd1, sticky_q, ABITS_FIELD, 4'd1};
   assign dmi_cap_op = busy ? OP_BUSY : sticky_q;
   assign upd_op     = sr_q[1:0];
   assign upd_data   = sr_q[33:2];
   assign upd_addr   = sr_q[DMI_W-1:34];

   // One shift register serves every DR; its effective length follows the selection.
   always_comb begin
      sr_d = sr_q;
      if (cap_ev) begin
         case (sel)
            SEL_IDCODE: sr_d = DMI_W'(IDCODE_VALUE);
            SEL_DTMCS:  sr_d = DMI_W'(dtmcs_cap);
            SEL_DMI:    sr_d = {addr_q, data_q, dmi_cap_op};
            default:    sr_d = '0;
         endcase
      end else if (shift_ev) begin
         case (sel)
            SEL_IDCODE: sr_d = DMI_W'({td_i, sr_q[31:1]});
            SEL_DTMCS:  sr_d = DMI_W'({td_i, sr_q[31:1]});
            SEL_DMI:    sr_d = {td_i, sr_q[DMI_W-1:1]};
            default:    sr_d = DMI_W'(td_i);
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         req_valid_q  <= 1'b0;
         resp_ready_q <= 1'b0;
         sr_q         <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         op_q         <= '0;
         sticky_q     <= '0;
         discard_q    <= 1'b0;
      end else begin
         sr_q <= sr_d;
         case (state_q)
            ST_IDLE: ;
            ST_REQ: begin
               if (dmi_req_ready_i) begin
                  state_q      <= ST_RESP;
                  req_valid_q  <= 1'b0;
                  resp_ready_q <= 1'b1;
               end
            end
            ST_RESP: begin
               if (dmi_resp_valid_i) begin
                  state_q      <= ST_IDLE;
                  resp_ready_q <= 1'b0;
                  if (discard_q) begin
                     discard_q <= 1'b0;
                  end else begin
                     if (op_q == OP_READ) data_q <= dmi_resp_data_i;
                     if (dmi_resp_err_i)  sticky_q <= 2'd2;
                  end
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               req_valid_q  <= 1'b0;
               resp_ready_q <= 1'b0;
            end
         endcase

         // TAP events come last so their sticky writes take priority over a response.
         if (cap_ev && sel == SEL_DMI && busy) sticky_q <= OP_BUSY;

         if (upd_ev && sel == SEL_DTMCS) begin
            if (sr_q[16] || sr_q[17]) sticky_q <= 2'd0;
            // A response finishing this very cycle leaves nothing to drop.
            if (sr_q[17] && busy && !resp_done) discard_q <= 1'b1;
         end

         if (upd_ev && sel == SEL_DMI && sticky_q == 2'd0) begin
            if (busy) begin
               sticky_q <= OP_BUSY;
            end else if (upd_op == OP_READ || upd_op == OP_WRITE) begin
               addr_q      <= upd_addr;
               data_q      <= upd_data;
               op_q        <= upd_op;
               state_q     <= ST_REQ;
               req_valid_q <= 1'b1;
            end
         end
      end
   end

   assign tdo_o            = sr_q[0];
   assign dmi_req_valid_o  = req_valid_q;
   assign dmi_resp_ready_o = resp_ready_q;
   assign dmi_req_addr_o   = addr_q;
   assign dmi_req_data_o   = data_q;
   assign dmi_req_op_o     = op_q;

endmodule

// File: tb/tb_armleocpu_jtag_dtm_ctrl.sv
// Bench for armleocpu_jtag_dtm_ctrl: a bit-queue DR model plus transaction model,
// checked every cycle, with directed TAP scans and literal expectations.
module tb_armleocpu_jtag_dtm_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tck_rise_i = 1'b0;
   logic [4:0]  ir_i = 5'h1F;
   logic        capture_dr_i = 1'b0;
   logic        shift_dr_i = 1'b0;
   logic        update_dr_i = 1'b0;
   logic        td_i = 1'b0;
   logic        tdo_o;
   logic        dmi_req_valid_o;
   logic        dmi_req_ready_i = 1'b0;
   logic [6:0]  dmi_req_addr_o;
   logic [31:0] dmi_req_data_o;
   logic [1:0]  dmi_req_op_o;
   logic        dmi_resp_valid_i = 1'b0;
   logic        dmi_resp_ready_o;
   logic [31:0] dmi_resp_data_i = 32'h0;
   logic        dmi_resp_err_i = 1'b0;

   armleocpu_jtag_dtm_ctrl #(
      .IR_LENGTH(5), .IDCODE_VALUE(32'h0000_0001), .ABITS(7)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tck_rise_i(tck_rise_i), .ir_i(ir_i),
      .capture_dr_i(capture_dr_i), .shift_dr_i(shift_dr_i), .update_dr_i(update_dr_i),
      .td_i(td_i), .tdo_o(tdo_o),
      .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
      .dmi_req_addr_o(dmi_req_addr_o), .dmi_req_data_o(dmi_req_data_o),
      .dmi_req_op_o(dmi_req_op_o), .dmi_resp_valid_i(dmi_resp_valid_i),
      .dmi_resp_ready_o(dmi_resp_ready_o), .dmi_resp_data_i(dmi_resp_data_i),
      .dmi_resp_err_i(dmi_resp_err_i)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_q[$];          // selected DR, element 0 is the next bit out on tdo
   int          m_phase;         // 0 no transaction, 1 request offered, 2 awaiting response
   logic [1:0]  m_sticky;
   bit          m_discard;
   logic [6:0]  m_addr;
   logic [31:0] m_data;
   logic [1:0]  m_op;
   int          o_phase;
   logic [1:0]  o_sticky;
   logic [6:0]  o_addr;
   logic [31:0] o_data;
   logic [1:0]  u_op;
   int          m_sel;

   function automatic int sel_of(input logic [4:0] ir);
      case (ir)
         5'h01:   return 1;
         5'h10:   return 2;
         5'h11:   return 3;
         default: return 0;
      endcase
   endfunction

   function automatic void load(input logic [63:0] v, input int w);
      m_q.delete();
      for (int i = 0; i < w; i++) m_q.push_back(v[i]);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_phase = 0; m_sticky = 2'd0; m_discard = 1'b0;
         m_addr = 7'd0; m_data = 32'd0; m_op = 2'd0;
      end else begin
         o_phase = m_phase; o_sticky = m_sticky; o_addr = m_addr; o_data = m_data;
         m_sel = sel_of(ir_i);
         if (o_phase == 2 && dmi_resp_valid_i) begin
            m_phase = 0;
            if (m_discard) m_discard = 1'b0;
            else begin
               if (m_op == 2'd1) m_data = dmi_resp_data_i;
               if (dmi_resp_err_i) m_sticky = 2'd2;
            end
         end
         if (o_phase == 1 && dmi_req_ready_i) m_phase = 2;
         if (tck_rise_i) begin
            if (capture_dr_i) begin
               case (m_sel)
                  1: load(64'h0000_0001, 32);
                  2: load({17'd0, 3'd1, o_sticky, 6'd7, 4'd1}, 32);
                  3: begin
                     load({o_addr, o_data, (o_phase != 0) ? 2'd3 : o_sticky}, 41);
                     if (o_phase != 0) m_sticky = 2'd3;
                  end
                  default: load(64'h0, 1);
               endcase
            end else if (shift_dr_i && m_q.size() > 0) begin
               void'(m_q.pop_front());
               m_q.push_back(td_i);
            end
            if (update_dr_i && m_sel == 2 && m_q.size() == 32) begin
               if (m_q[16] || m_q[17]) m_sticky = 2'd0;
               if (m_q[17] && o_phase != 0 && !(o_phase == 2 && dmi_resp_valid_i)) m_discard = 1'b1;
            end
            if (update_dr_i && m_sel == 3 && m_q.size() == 41 && o_sticky == 2'd0) begin
               if (o_phase != 0) m_sticky = 2'd3;
               else begin
                  u_op = {m_q[1], m_q[0]};
                  if (u_op == 2'd1 || u_op == 2'd2) begin
                     m_op = u_op;
                     for (int i = 0; i < 32; i++) m_data[i] = m_q[2 + i];
                     for (int i = 0; i < 7; i++)  m_addr[i] = m_q[34 + i];
                     m_phase = 1;
                  end
               end
            end
         end
      end
   end

   // Per-cycle compare, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         check("req_valid", dmi_req_valid_o, m_phase == 1);
         check("resp_ready", dmi_resp_ready_o, m_phase == 2);
         if (m_phase == 1)
            check("req_fields", {dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}, {m_addr, m_data, m_op});
         if (shift_dr_i && m_q.size() > 0) check("tdo", tdo_o, m_q[0]);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic dr_capture();
      capture_dr_i = 1'b1; tck_rise_i = 1'b1; tick();
      tck_rise_i = 1'b0; tick();          // strobe without tck_rise must do nothing
      capture_dr_i = 1'b0;
   endtask

   task automatic dr_shift(input int n, input logic [63:0] din, output logic [63:0] dout);
      dout = '0;
      shift_dr_i = 1'b1;
      for (int i = 0; i < n; i++) begin
         td_i = din[i];
         dout[i] = tdo_o;
         tck_rise_i = 1'b1; tick();
         tck_rise_i = 1'b0; tick();
      end
      shift_dr_i = 1'b0; td_i = 1'b0;
   endtask

   task automatic dr_update();
      update_dr_i = 1'b1; tck_rise_i = 1'b1; tick();
      update_dr_i = 1'b0; tck_rise_i = 1'b0;
   endtask

   task automatic scan(input logic [4:0] ir, input int n, input logic [63:0] din,
                       output logic [63:0] dout);
      ir_i = ir;
      dr_capture();
      dr_shift(n, din, dout);
   endtask

   task automatic dmi_update(input logic [6:0] addr, input logic [31:0] data, input logic [1:0] op);
      logic [63:0] d;
      scan(5'h11, 41, {23'd0, addr, data, op}, d);
      dr_update();
   endtask

   task automatic accept();
      int n = 0;
      while (!dmi_req_valid_o && n < 20) begin tick(); n++; end
      check("accept_valid_seen", dmi_req_valid_o, 1);
      dmi_req_ready_i = 1'b1; tick();
      dmi_req_ready_i = 1'b0;
   endtask

   task automatic respond(input logic [31:0] data, input logic err);
      int n = 0;
      while (!dmi_resp_ready_o && n < 20) begin tick(); n++; end
      check("resp_ready_seen", dmi_resp_ready_o, 1);
      dmi_resp_valid_i = 1'b1; dmi_resp_data_i = data; dmi_resp_err_i = err; tick();
      dmi_resp_valid_i = 1'b0; dmi_resp_data_i = '0; dmi_resp_err_i = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] d;
      int cnt;

      repeat (3) @(posedge clk);
      #2;
      check("reset_outputs", {tdo_o, dmi_req_valid_o, dmi_resp_ready_o, dmi_req_addr_o,
                              dmi_req_data_o, dmi_req_op_o}, 64'h0);
      rst_n = 1'b1;
      tick();

      scan(5'h01, 32, 64'h0, d);
      check("idcode", d[31:0], 32'h0000_0001);

      scan(5'h1F, 4, 64'b1101, d);
      check("bypass_delay", d[3:0], 4'b1010);

      scan(5'h05, 4, 64'b0110, d);
      check("bypass_other_ir", d[3:0], 4'b1100);

      scan(5'h10, 32, 64'h0, d);
      check("dtmcs_reset", d[31:0], 32'h0000_1071);

      // Write with ready held low three cycles.
      dmi_update(7'h10, 32'hDEADBEEF, 2'd2);
      check("req_latency", dmi_req_valid_o, 1);
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         dmi_req_ready_i = (k == 3);
         if (dmi_req_valid_o) cnt++;
         tick();
      end
      dmi_req_ready_i = 1'b0;
      check("valid_hold_cycles", cnt, 4);
      check("resp_ready_after_accept", {dmi_req_valid_o, dmi_resp_ready_o}, 2'b01);
      respond(32'h0, 1'b0);
      scan(5'h11, 41, 64'h0, d);
      check("dmi_after_write", d[40:0], {7'h10, 32'hDEADBEEF, 2'd0});

      // Read returns response data.
      dmi_update(7'h11, 32'h0, 2'd1);
      accept();
      respond(32'h1234_5678, 1'b0);
      scan(5'h11, 41, 64'h0, d);
      check("dmi_after_read", d[40:0], {7'h11, 32'h1234_5678, 2'd0});

      // Update while a response is pending sets busy sticky.
      dmi_update(7'h15, 32'h0BAD_F00D, 2'd2);
      accept();
      dr_update();
      check("no_second_req", {dmi_req_valid_o, dmi_resp_ready_o}, 2'b01);
      respond(32'h0, 1'b0);
      tick();
      check("no_req_after_busy", dmi_req_valid_o, 0);
      scan(5'h11, 41, 64'h0, d);
      check("dmi_op_busy", d[1:0], 2'd3);
      scan(5'h10, 32, 64'h0001_0000, d);
      check("dtmcs_busy", d[31:0], 32'h0000_1C71);
      dr_update();
      scan(5'h10, 32, 64'h0, d);
      check("dtmcs_after_dmireset", d[31:0], 32'h0000_1071);

      // Error response blocks further requests until dmireset.
      dmi_update(7'h13, 32'h1111_2222, 2'd2);
      accept();
      respond(32'h0, 1'b1);
      dmi_update(7'h14, 32'h0, 2'd1);
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         if (dmi_req_valid_o) cnt++;
         tick();
      end
      check("err_blocks_req", cnt, 0);
      scan(5'h11, 41, 64'h0, d);
      check("dmi_op_err", d[1:0], 2'd2);
      scan(5'h10, 32, 64'h0001_0000, d);
      check("dtmcs_err", d[31:0], 32'h0000_1871);
      dr_update();
      dmi_update(7'h14, 32'h0, 2'd1);
      check("req_after_dmireset", dmi_req_valid_o, 1);
      accept();
      respond(32'hA5A5_0F0F, 1'b0);
      scan(5'h11, 41, 64'h0, d);
      check("dmi_after_reset_read", d[40:0], {7'h14, 32'hA5A5_0F0F, 2'd0});

      // dmihardreset while a request is pending: response dropped.
      dmi_update(7'h12, 32'h55AA_55AA, 2'd1);
      scan(5'h10, 32, 64'h0002_0000, d);
      dr_update();
      check("valid_survives_hardreset", dmi_req_valid_o, 1);
      accept();
      respond(32'hCAFE_F00D, 1'b1);
      scan(5'h11, 41, 64'h0, d);
      check("dmi_after_discard", d[40:0], {7'h12, 32'h55AA_55AA, 2'd0});

      // Asynchronous reset mid-request.
      dmi_update(7'h01, 32'h0, 2'd1);
      #1 rst_n = 1'b0;
      #1 check("async_reset_drop", {dmi_req_valid_o, dmi_resp_ready_o, dmi_req_addr_o}, 0);
      tick();
      rst_n = 1'b1;
      tick();
      scan(5'h10, 32, 64'h0, d);
      check("dtmcs_after_reset", d[31:0], 32'h0000_1071);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
